multdiv_sequencer: RTL and testbench

Control sequencer for the shared multiply/divide datapath: one 32-bit add/sub ALU, product/remainder shift registers and the quotient register. Accepts single-cycle `ctrl_MULT` / `ctrl_DIV` requests and steps the datapath through radix-4 Booth multiplication (16 steps) or non-restoring division (32 steps plus one correction step). Reports completion and exceptions to the processor stall logic. Replaces the per-unit free-running counters with one explicit FSM and counter shared by both operations.

---
 rtl/multdiv_pkg.sv | 22 ++
 rtl/multdiv_step_counter.sv | 36 +++
 rtl/multdiv_sequencer.sv | 162 ++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multiply/divide sequencer
// Purpose: FSM state encoding, ALU operation codes and default step counts.
// Ports: none (package).
package multdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] ALU_NOP = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  localparam int MULT_STEPS_DEF = 16;
  localparam int DIV_STEPS_DEF  = 32;
  localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/multdiv_step_counter.sv
// rtl/multdiv_step_counter.sv - step counter shared by multiply and divide
// Purpose: CNT_W-bit up counter with synchronous clear and count enable.
// Ports:
//   clock, reset_n : clock, synchronous active-low reset
//   i_clr          : clear to zero (wins over i_en)
//   i_en           : increment this cycle
//   i_tc_val       : terminal count to compare against
//   o_tc           : current count equals i_tc_val
module multdiv_step_counter
  import multdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tc_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - control FSM for the shared multiply/divide datapath
// Purpose: sequences radix-4 Booth multiply and non-restoring divide (+1 correction).
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   ctrl_MULT, ctrl_DIV     : single-cycle operation requests (multiply wins)
//   divisor_zero            : divisor operand is zero, valid in request cycle
//   booth_bits              : {Q[1],Q[0],Q[-1]} for Booth decode
//   acc_msb, alu_sign       : partial remainder sign, current ALU result sign
//   mult_overflow           : datapath overflow flag, valid in DONE
//   dp_load, dp_shift       : operand load / commit-and-shift strobes
//   alu_op, alu_x2          : ALU op (NOP/ADD/SUB) and 2x multiplicand select
//   q_bit, fix_remainder    : quotient bit, remainder correction commit
//   sign_fix                : apply operand sign correction
//   busy, data_resultRDY    : operation in progress, one-cycle result pulse
//   data_exception          : qualifies data_resultRDY
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int MULT_STEPS = MULT_STEPS_DEF,
  parameter int DIV_STEPS  = DIV_STEPS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ctrl_MULT,
  input  logic       ctrl_DIV,
  input  logic       divisor_zero,
  input  logic [2:0] booth_bits,
  input  logic       acc_msb,
  input  logic       alu_sign,
  input  logic       mult_overflow,
  output logic       dp_load,
  output logic       dp_shift,
  output logic [1:0] alu_op,
  output logic       alu_x2,
  output logic       q_bit,
  output logic       fix_remainder,
  output logic       sign_fix,
  output logic       busy,
  output logic       data_resultRDY,
  output logic       data_exception
);

  localparam logic [CNT_W-1:0] MULT_TC = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_TC  = CNT_W'(DIV_STEPS - 1);

  state_t           r_state;
  state_t           w_state_n;
  logic             r_div_zero;
  logic             r_is_mult;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_tc_val;
  logic             w_tc;

  multdiv_step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .i_tc_val (w_tc_val),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_div_zero <= 1'b0;
      r_is_mult  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      // Remember which operation finishes in DONE so the exception source is right.
      if (dp_load) begin
        r_div_zero <= ~ctrl_MULT & ctrl_DIV & divisor_zero;
        r_is_mult  <= ctrl_MULT;
      end
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_cnt_clr      = 1'b0;
    w_cnt_en       = 1'b0;
    w_tc_val       = MULT_TC;
    dp_load        = 1'b0;
    dp_shift       = 1'b0;
    alu_op         = ALU_NOP;
    alu_x2         = 1'b0;
    q_bit          = 1'b0;
    fix_remainder  = 1'b0;
    sign_fix       = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (r_state == ST_DONE) begin
          data_resultRDY = 1'b1;
          data_exception = r_div_zero | (r_is_mult & mult_overflow);
          w_state_n      = ST_IDLE;
        end
        dp_load = ctrl_MULT | ctrl_DIV;
        if (ctrl_MULT) begin
          w_state_n = ST_MULT;
          w_cnt_clr = 1'b1;
        end else if (ctrl_DIV) begin
          // A zero divisor skips the datapath entirely and reports straight away.
          w_state_n = divisor_zero ? ST_DONE : ST_DIV;
          w_cnt_clr = 1'b1;
        end
      end

      ST_MULT: begin
        busy     = 1'b1;
        dp_shift = 1'b1;
        w_cnt_en = 1'b1;
        w_tc_val = MULT_TC;
        case (booth_bits)
          3'b001, 3'b010: alu_op = ALU_ADD;
          3'b011: begin
            alu_op = ALU_ADD;
            alu_x2 = 1'b1;
          end
          3'b100: begin
            alu_op = ALU_SUB;
            alu_x2 = 1'b1;
          end
          3'b101, 3'b110: alu_op = ALU_SUB;
          default: alu_op = ALU_NOP;
        endcase
        if (w_tc) w_state_n = ST_DONE;
      end

      ST_DIV: begin
        busy     = 1'b1;
        dp_shift = 1'b1;
        w_cnt_en = 1'b1;
        w_tc_val = DIV_TC;
        alu_op   = acc_msb ? ALU_ADD : ALU_SUB;
        q_bit    = ~alu_sign;
        if (w_tc) w_state_n = ST_FIX;
      end

      ST_FIX: begin
        busy     = 1'b1;
        sign_fix = 1'b1;
        // Negative final remainder needs the divisor added back once.
        if (acc_msb) begin
          alu_op        = ALU_ADD;
          fix_remainder = 1'b1;
        end
        w_state_n = ST_DONE;
      end

      default: w_state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - directed self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ctrl_MULT, ctrl_DIV, divisor_zero;
  logic [2:0] booth_bits;
  logic       acc_msb, alu_sign, mult_overflow;
  logic       dp_load, dp_shift;
  logic [1:0] alu_op;
  logic       alu_x2, q_bit, fix_remainder, sign_fix, busy;
  logic       data_resultRDY, data_exception;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

  typedef struct {
    logic [2:0] booth;
    logic [1:0] op;
    logic       x2;
  } booth_vec_t;

  typedef struct {
    logic       acc;
    logic       sgn;
    logic [1:0] op;
    logic       q;
  } div_vec_t;

  booth_vec_t bt[8];
  div_vec_t   dt[4];

  always #5 clock = ~clock;

  multdiv_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .divisor_zero   (divisor_zero),
    .booth_bits     (booth_bits),
    .acc_msb        (acc_msb),
    .alu_sign       (alu_sign),
    .mult_overflow  (mult_overflow),
    .dp_load        (dp_load),
    .dp_shift       (dp_shift),
    .alu_op         (alu_op),
    .alu_x2         (alu_x2),
    .q_bit          (q_bit),
    .fix_remainder  (fix_remainder),
    .sign_fix       (sign_fix),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  // Bit order: load, shift, op[1:0], x2, q, fix, sign_fix, busy, rdy, exc
  function automatic logic [10:0] mk(input logic ld, input logic sh, input logic [1:0] op,
                                     input logic x2, input logic q, input logic fx,
                                     input logic sf, input logic bz, input logic rd,
                                     input logic ex);
    return {ld, sh, op, x2, q, fx, sf, bz, rd, ex};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [10:0] exp);
    logic [10:0] act;
    #1;
    act = {dp_load, dp_shift, alu_op, alu_x2, q_bit, fix_remainder, sign_fix, busy,
           data_resultRDY, data_exception};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] got=%b exp=%b", name, idx, act, exp);
    end
  endtask

  task automatic clr_in();
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; divisor_zero = 1'b0; booth_bits = 3'b000;
    acc_msb = 1'b0; alu_sign = 1'b0; mult_overflow = 1'b0;
  endtask

  localparam logic [10:0] O_ZERO = 11'b0;

  initial begin
    bt[0] = '{3'b000, NOP, 1'b0};
    bt[1] = '{3'b001, ADD, 1'b0};
    bt[2] = '{3'b010, ADD, 1'b0};
    bt[3] = '{3'b011, ADD, 1'b1};
    bt[4] = '{3'b100, SUB, 1'b1};
    bt[5] = '{3'b101, SUB, 1'b0};
    bt[6] = '{3'b110, SUB, 1'b0};
    bt[7] = '{3'b111, NOP, 1'b0};
    dt[0] = '{1'b0, 1'b0, SUB, 1'b1};
    dt[1] = '{1'b0, 1'b1, SUB, 1'b0};
    dt[2] = '{1'b1, 1'b0, ADD, 1'b1};
    dt[3] = '{1'b1, 1'b1, ADD, 1'b0};

    clr_in();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("reset", 0, O_ZERO);

    // Multiply, booth 011 held for all steps
    ctrl_MULT = 1'b1; booth_bits = 3'b011;
    chk("m_req", 0, mk(1,0,NOP,0,0,0,0,0,0,0));
    tick();
    ctrl_MULT = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("m_step", i, mk(0,1,ADD,1,0,0,0,1,0,0));
      tick();
    end
    chk("m_done", 17, mk(0,0,NOP,0,0,0,0,0,1,0));
    tick();
    chk("m_idle", 18, O_ZERO);

    // Booth decode table applied over the first 8 multiply steps
    ctrl_MULT = 1'b1; booth_bits = 3'b000;
    chk("bt_req", 0, mk(1,0,NOP,0,0,0,0,0,0,0));
    tick();
    ctrl_MULT = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        booth_bits = bt[i].booth;
        chk("booth", i, mk(0,1,bt[i].op,bt[i].x2,0,0,0,1,0,0));
      end else begin
        booth_bits = 3'b000;
        chk("bt_tail", i, mk(0,1,NOP,0,0,0,0,1,0,0));
      end
      tick();
    end
    chk("bt_done", 17, mk(0,0,NOP,0,0,0,0,0,1,0));
    tick();

    // Divide, acc_msb toggling, alu_sign=1, FIX with acc_msb=1
    alu_sign = 1'b1; ctrl_DIV = 1'b1;
    chk("d_req", 0, mk(1,0,NOP,0,0,0,0,0,0,0));
    tick();
    ctrl_DIV = 1'b0;
    for (int i = 0; i < 32; i++) begin
      acc_msb = i[0];
      chk("d_step", i + 1, mk(0,1,(i[0] ? ADD : SUB),0,0,0,0,1,0,0));
      tick();
    end
    acc_msb = 1'b1;
    chk("d_fix", 33, mk(0,0,ADD,0,0,1,1,1,0,0));
    tick();
    acc_msb = 1'b0;
    chk("d_done", 34, mk(0,0,NOP,0,0,0,0,0,1,0));
    tick();
    chk("d_idle", 35, O_ZERO);

    // Divide decode table, FIX with acc_msb=0 is NOP
    clr_in();
    ctrl_DIV = 1'b1;
    chk("dt_req", 0, mk(1,0,NOP,0,0,0,0,0,0,0));
    tick();
    ctrl_DIV = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < 4) begin
        acc_msb = dt[i].acc; alu_sign = dt[i].sgn;
        chk("div", i, mk(0,1,dt[i].op,0,dt[i].q,0,0,1,0,0));
      end else begin
        acc_msb = 1'b0; alu_sign = 1'b0;
        chk("dt_tail", i, mk(0,1,SUB,0,1,0,0,1,0,0));
      end
      tick();
    end
    chk("dt_fix", 33, mk(0,0,NOP,0,0,0,1,1,0,0));
    tick();
    chk("dt_done", 34, mk(0,0,NOP,0,0,0,0,0,1,0));
    tick();

    // Divide by zero
    ctrl_DIV = 1'b1; divisor_zero = 1'b1;
    chk("dz_req", 0, mk(1,0,NOP,0,0,0,0,0,0,0));
    tick();
    clr_in();
    chk("dz_done", 1, mk(0,0,NOP,0,0,0,0,0,1,1));
    tick();
    chk("dz_idle", 2, O_ZERO);

    // Simultaneous requests: multiply only; later pulses ignored
    ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
    chk("both_req", 0, mk(1,0,NOP,0,0,0,0,0,0,0));
    tick();
    for (int i = 1; i <= 16; i++) begin
      ctrl_MULT = (i == 5);
      ctrl_DIV  = (i == 10);
      chk("both_step", i, mk(0,1,NOP,0,0,0,0,1,0,0));
      tick();
    end
    clr_in();
    chk("both_done", 17, mk(0,0,NOP,0,0,0,0,0,1,0));
    tick();
    chk("both_idle", 18, O_ZERO);

    // Overflow exception, back-to-back divide, then reset mid-divide
    ctrl_MULT = 1'b1;
    chk("ov_req", 0, mk(1,0,NOP,0,0,0,0,0,0,0));
    tick();
    ctrl_MULT = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("ov_step", i, mk(0,1,NOP,0,0,0,0,1,0,0));
      tick();
    end
    mult_overflow = 1'b1; ctrl_DIV = 1'b1;
    chk("ov_done", 17, mk(1,0,NOP,0,0,0,0,0,1,1));
    tick();
    clr_in();
    for (int i = 1; i <= 20; i++) begin
      chk("b2b_div", i, mk(0,1,SUB,0,1,0,0,1,0,0));
      if (i == 20) reset_n = 1'b0;
      tick();
    end
    reset_n = 1'b1;
    chk("rst_abort", 0, O_ZERO);
    tick();
    for (int i = 1; i <= 20; i++) begin
      chk("rst_quiet", i, O_ZERO);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
